// File: rtl/exu_mc.sv
// Multi-cycle execution unit: single-cycle ALU/branch ops plus an iterative
// shift-add multiplier and restoring divider, sharing one valid/ready handshake.
module exu_mc #(
  parameter int XLEN = 64,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  aluop,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            pcsel,
  output logic [XLEN-1:0] dnpc,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_AND   = OPW'(2);
  localparam logic [OPW-1:0] OP_OR    = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(5);
  localparam logic [OPW-1:0] OP_SRL   = OPW'(6);
  localparam logic [OPW-1:0] OP_SRA   = OPW'(7);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(8);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(9);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(10);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(11);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(12);
  localparam logic [OPW-1:0] OP_BGE   = OPW'(13);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(15);
  localparam logic [OPW-1:0] OP_MULHU = OPW'(16);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(17);
  localparam logic [OPW-1:0] OP_REMU  = OPW'(18);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(19);
  localparam logic [OPW-1:0] OP_REM   = OPW'(20);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [SW-1:0]   cnt;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd;
  logic            qneg_q;
  logic            rneg_q;
  logic            divz_q;

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] s_res;
  logic            s_pcsel;
  logic [XLEN-1:0] s_dnpc;
  logic            is_mul;
  logic            is_div;
  logic            is_sdiv;

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_n;
  logic [XLEN-1:0] mul_lo_n;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ok;
  logic [XLEN-1:0] div_q_n;
  logic [XLEN-1:0] div_r_n;
  logic [XLEN-1:0] mc_res;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL) || (state == S_DIV);

  assign shamt   = op2[SW-1:0];
  assign target  = pc + imm;
  assign is_mul  = (aluop == OP_MUL) || (aluop == OP_MULHU);
  assign is_div  = (aluop >= OP_DIVU) && (aluop <= OP_REM);
  assign is_sdiv = (aluop == OP_DIV) || (aluop == OP_REM);

  always_comb begin
    s_res   = '0;
    s_pcsel = 1'b0;
    s_dnpc  = '0;
    case (aluop)
      OP_ADD:  s_res = op1 + op2;
      OP_SUB:  s_res = op1 - op2;
      OP_AND:  s_res = op1 & op2;
      OP_OR:   s_res = op1 | op2;
      OP_XOR:  s_res = op1 ^ op2;
      OP_SLL:  s_res = op1 << shamt;
      OP_SRL:  s_res = op1 >> shamt;
      OP_SRA:  s_res = $signed(op1) >>> shamt;
      OP_SLT:  s_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: s_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      OP_BEQ:  begin s_pcsel = (op1 == op2); s_dnpc = target; end
      OP_BNE:  begin s_pcsel = (op1 != op2); s_dnpc = target; end
      OP_BLT:  begin s_pcsel = ($signed(op1) < $signed(op2)); s_dnpc = target; end
      OP_BGE:  begin s_pcsel = ($signed(op1) >= $signed(op2)); s_dnpc = target; end
      OP_JAL:  begin s_res = pc + XLEN'(4); s_pcsel = 1'b1; s_dnpc = target; end
      default: ;
    endcase
  end

  // One multiply step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole {carry, hi, lo} right.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign mul_hi_n = mul_sum[XLEN:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};

  // One restoring-division step; acc_lo shifts dividend bits out and quotient bits in.
  assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign div_ok   = ~div_diff[XLEN];
  assign div_q_n  = {acc_lo[XLEN-2:0], div_ok};
  assign div_r_n  = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];

  always_comb begin
    mc_res = '0;
    case (op_q)
      OP_MUL:   mc_res = mul_lo_n;
      OP_MULHU: mc_res = mul_hi_n;
      OP_DIVU:  mc_res = divz_q ? '1 : div_q_n;
      OP_REMU:  mc_res = divz_q ? a_q : div_r_n;
      OP_DIV:   mc_res = divz_q ? '1 : (qneg_q ? -div_q_n : div_q_n);
      OP_REM:   mc_res = divz_q ? a_q : (rneg_q ? -div_r_n : div_r_n);
      default:  ;
    endcase
  end

  // Control FSM and datapath registers; output registers load only on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      divz_q <= 1'b0;
      result <= '0;
      pcsel  <= 1'b0;
      dnpc   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= aluop;
            a_q    <= op1;
            cnt    <= SW'(XLEN-1);
            acc_hi <= '0;
            if (is_mul) begin
              state  <= S_MUL;
              opnd   <= op1;
              acc_lo <= op2;
            end else if (is_div) begin
              state  <= S_DIV;
              opnd   <= (is_sdiv && op2[XLEN-1]) ? -op2 : op2;
              acc_lo <= (is_sdiv && op1[XLEN-1]) ? -op1 : op1;
              qneg_q <= is_sdiv && (op1[XLEN-1] ^ op2[XLEN-1]);
              rneg_q <= is_sdiv && op1[XLEN-1];
              divz_q <= (op2 == '0);
            end else begin
              state  <= S_DONE;
              result <= s_res;
              pcsel  <= s_pcsel;
              dnpc   <= s_dnpc;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_hi <= (state == S_MUL) ? mul_hi_n : div_r_n;
          acc_lo <= (state == S_MUL) ? mul_lo_n : div_q_n;
          if (cnt == '0) begin
            state  <= S_DONE;
            result <= mc_res;
            pcsel  <= 1'b0;
            dnpc   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_mc.sv
// Self-checking bench for exu_mc: directed vector table, multi-cycle corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_exu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  aluop = '0;
  logic [63:0] op1 = '0, op2 = '0, pc = '0, imm = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        pcsel;
  logic [63:0] dnpc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  exu_mc #(.XLEN(64), .OPW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .op1(op1), .op2(op2), .pc(pc), .imm(imm),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .pcsel(pcsel), .dnpc(dnpc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a, b, p, i;
    logic [63:0] exp_res;
    logic        exp_pcsel;
    logic [63:0] exp_dnpc;
    int          exp_lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the operation definitions, using wide arithmetic.
  task automatic ref_model(input logic [4:0] op, input logic [63:0] a, b, p, i,
                           output logic [63:0] r, output logic ps, output logic [63:0] dn);
    logic [127:0] prod;
    int sh;
    sh   = int'(b[5:0]);
    prod = {64'd0, a} * {64'd0, b};
    r = '0; ps = 1'b0; dn = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << sh;
      5'd6:  r = a >> sh;
      5'd7:  r = $signed(a) >>> sh;
      5'd8:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      5'd9:  r = (a < b) ? 64'd1 : 64'd0;
      5'd10: begin ps = (a == b); dn = p + i; end
      5'd11: begin ps = (a != b); dn = p + i; end
      5'd12: begin ps = ($signed(a) < $signed(b)); dn = p + i; end
      5'd13: begin ps = ($signed(a) >= $signed(b)); dn = p + i; end
      5'd14: begin r = p + 64'd4; ps = 1'b1; dn = p + i; end
      5'd15: r = prod[63:0];
      5'd16: r = prod[127:64];
      5'd17: r = (b == 0) ? '1 : a / b;
      5'd18: r = (b == 0) ? a : a % b;
      5'd19: begin
        if (b == 0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = $signed(a) / $signed(b);
      end
      5'd20: begin
        if (b == 0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
        else r = $signed(a) % $signed(b);
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [63:0] a, b, p, i,
                               output logic [63:0] r, output logic ps, output logic [63:0] dn,
                               output int lat, output int bcnt);
    @(negedge clk);
    checkOutput("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    aluop = op; op1 = a; op2 = b; pc = p; imm = i; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!out_valid && lat < 200);
    r = result; ps = pcsel; dn = dnpc;
    if (out_valid) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic expect_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    checkOutput(name, {63'd0, seen}, 64'd0);
  endtask

  vec_t vecs[$];
  logic [63:0] r, dn, er, edn;
  logic        ps, eps;
  int          lat, bcnt;

  initial begin
    vecs.push_back('{5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1});
    vecs.push_back('{5'd15, 64'd3, 64'd5, 64'd0, 64'd0, 64'd15, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd16, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0,
                     64'h4000_0000_0000_0000, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd19, -64'sd7, 64'd2, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd20, -64'sd7, 64'd2, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd17, 64'd123, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd18, 64'd123, 64'd0, 64'd0, 64'd0, 64'd123, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd19, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                     64'h8000_0000_0000_0000, 1'b0, 64'd0, 65});
    vecs.push_back('{5'd11, 64'd1, 64'd2, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1,
                     64'h7FFF_FFF8, 1});
    vecs.push_back('{5'd14, 64'd0, 64'd0, 64'h8000_0000, 64'h10, 64'h8000_0004, 1'b1, 64'h8000_0010, 1});
    vecs.push_back('{5'd10, 64'd5, 64'd6, 64'h100, 64'h20, 64'd0, 1'b0, 64'h120, 1});
    vecs.push_back('{5'd7,  64'h8000_0000_0000_0000, 64'd68, 64'd0, 64'd0, 64'hF800_0000_0000_0000, 1'b0, 64'd0, 1});
    vecs.push_back('{5'd5,  64'd1, 64'd63, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1});
    vecs.push_back('{5'd9,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd1, 1'b0, 64'd0, 1});
    vecs.push_back('{5'd25, 64'd7, 64'd9, 64'h40, 64'h8, 64'd0, 1'b0, 64'd0, 1});

    // Reset values while rst is held low
    #12;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_pcsel", {63'd0, pcsel}, 64'd0);
    checkOutput("reset_dnpc", dnpc, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].i, r, ps, dn, lat, bcnt);
      checkOutput($sformatf("vec%0d_result", k), r, vecs[k].exp_res);
      checkOutput($sformatf("vec%0d_pcsel", k), {63'd0, ps}, {63'd0, vecs[k].exp_pcsel});
      checkOutput($sformatf("vec%0d_dnpc", k), dn, vecs[k].exp_dnpc);
      checkOutput($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
      checkOutput($sformatf("vec%0d_busy_cycles", k), 64'(bcnt), 64'(vecs[k].exp_lat - 1));
    end

    // Consumer stalls for five cycles in DONE
    @(negedge clk);
    aluop = 5'd0; op1 = 64'd10; op2 = 64'd20; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("stall_result", result, 64'd30);
      checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("stall_release_out_valid", {63'd0, out_valid}, 64'd0);

    // flush together with in_valid in IDLE must not accept
    @(negedge clk);
    aluop = 5'd0; op1 = 64'd1; op2 = 64'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    expect_no_valid("flush_idle_no_accept", 4);

    // flush at DIV iteration 10
    @(negedge clk);
    aluop = 5'd19; op1 = 64'd1000; op2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_div_in_ready", {63'd0, in_ready}, 64'd1);
    expect_no_valid("flush_div_no_valid", 80);
    applyStimulus(5'd0, 64'd2, 64'd2, 64'd0, 64'd0, r, ps, dn, lat, bcnt);
    checkOutput("after_flush_add", r, 64'd4);

    // asynchronous reset at MUL iteration 3, asserted away from any clock edge
    @(negedge clk);
    aluop = 5'd15; op1 = 64'd12345; op2 = 64'd678; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("async_rst_result", result, 64'd0);
    @(negedge clk) rst = 1'b1;
    expect_no_valid("rst_mul_no_valid", 80);
    applyStimulus(5'd0, 64'd2, 64'd2, 64'd0, 64'd0, r, ps, dn, lat, bcnt);
    checkOutput("after_rst_add", r, 64'd4);

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [4:0]  op;
      logic [63:0] a, b, p, i;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'($urandom_range(0, 3));
        1: a = {{32{a[31]}}, a[31:0]};
        2: b = a;
        3: b = '1;
        default: ;
      endcase
      p  = {$urandom, $urandom};
      i  = {{32{b[31]}}, $urandom};
      ref_model(op, a, b, p, i, er, eps, edn);
      applyStimulus(op, a, b, p, i, r, ps, dn, lat, bcnt);
      checkOutput($sformatf("rand%0d_op%0d_result", n, op), r, er);
      checkOutput($sformatf("rand%0d_op%0d_pcsel", n, op), {63'd0, ps}, {63'd0, eps});
      checkOutput($sformatf("rand%0d_op%0d_dnpc", n, op), dn, edn);
      checkOutput($sformatf("rand%0d_op%0d_latency", n, op), 64'(lat),
                  (op >= 5'd15 && op <= 5'd20) ? 64'd65 : 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
